// File: rtl/esc_pkg.sv
// Shared types and byte constants for the key-to-escape-sequence encoder.
// ESC_ENTER_CRLF_EN adds the LF state so ENTER emits CR LF instead of CR.
package esc_pkg;

  typedef enum logic [2:0] {
    KeyChar      = 3'd0,
    KeyLeft      = 3'd1,
    KeyRight     = 3'd2,
    KeyDelete    = 3'd3,
    KeySpace     = 3'd4,
    KeyBackspace = 3'd5,
    KeyEnter     = 3'd6,
    KeyRsvd      = 3'd7
  } key_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StEsc,
    StCsi,
    StParam,
    StFinal,
`ifdef ESC_ENTER_CRLF_EN
    StSingle,
    StLf
`else
    StSingle
`endif
  } state_e;

  localparam logic [7:0] ESC_B = 8'h1B;
  localparam logic [7:0] CSI_B = 8'h5B;
  localparam logic [7:0] CUR_R = 8'h43;
  localparam logic [7:0] CUR_L = 8'h44;
  localparam logic [7:0] DEL_P = 8'h33;
  localparam logic [7:0] DEL_T = 8'h7E;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] SP    = 8'h20;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/esc_seq_rom.sv
// Byte-selection table: maps (state, latched key, latched char) to the byte sent in that state.
// ESC_ENTER_CRLF_EN enables the LF entry.
module esc_seq_rom
  import esc_pkg::*;
#(
  parameter logic [7:0] BS_CODE = 8'h08
) (
  input  state_e      state_i,
  input  key_code_e   key_i,
  input  logic [7:0]  char_i,
  output logic [7:0]  byte_o
);

  always_comb begin
    byte_o = 8'h00;
    case (state_i)
      StEsc:   byte_o = ESC_B;
      StCsi:   byte_o = CSI_B;
      StParam: byte_o = DEL_P;
      StFinal: begin
        case (key_i)
          KeyLeft:  byte_o = CUR_L;
          KeyRight: byte_o = CUR_R;
          default:  byte_o = DEL_T;
        endcase
      end
      StSingle: begin
        case (key_i)
          KeySpace:     byte_o = SP;
          KeyBackspace: byte_o = BS_CODE;
          KeyEnter:     byte_o = CR;
          default:      byte_o = char_i;
        endcase
      end
`ifdef ESC_ENTER_CRLF_EN
      StLf:    byte_o = LF;
`endif
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/esc_seq_encoder.sv
// Converts key events into terminal byte sequences (VT cursor/delete escapes or single bytes).
// ESC_ENTER_CRLF_EN makes ENTER emit CR LF.
module esc_seq_encoder
  import esc_pkg::*;
#(
  parameter logic [7:0] BS_CODE = 8'h08
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [2:0] key_code,
  input  logic [7:0] key_char,
  output logic       key_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       err
);

  state_e     state_q, state_d;
  key_code_e  key_q, key_d;
  logic [7:0] char_q, char_d;
  logic [7:0] tx_data_q, rom_byte;
  logic       tx_valid_q;
  logic       err_q, err_d;

  assign key_ready = (state_q == StIdle);
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    char_d  = char_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (key_valid) begin
          key_d  = key_code_e'(key_code);
          char_d = key_char;
          case (key_code_e'(key_code))
            KeyLeft, KeyRight, KeyDelete:    state_d = StEsc;
            KeySpace, KeyBackspace, KeyEnter: state_d = StSingle;
            KeyChar: begin
              if (is_printable(key_char)) state_d = StSingle;
              else                        err_d   = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StEsc:   if (tx_ready) state_d = StCsi;
      StCsi:   if (tx_ready) state_d = (key_q == KeyDelete) ? StParam : StFinal;
      StParam: if (tx_ready) state_d = StFinal;
      StFinal: if (tx_ready) state_d = StIdle;
`ifdef ESC_ENTER_CRLF_EN
      StSingle: if (tx_ready) state_d = (key_q == KeyEnter) ? StLf : StIdle;
      StLf:     if (tx_ready) state_d = StIdle;
`else
      StSingle: if (tx_ready) state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Look up the byte for the state being entered so tx_data can be registered with
  // the state, giving the first byte on the cycle after acceptance.
  esc_seq_rom #(
    .BS_CODE (BS_CODE)
  ) u_rom (
    .state_i (state_d),
    .key_i   (key_d),
    .char_i  (char_d),
    .byte_o  (rom_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      key_q      <= KeyChar;
      char_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      char_q     <= char_d;
      tx_data_q  <= rom_byte;
      tx_valid_q <= (state_d != StIdle);
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_esc_seq_encoder.sv
// Directed bench for esc_seq_encoder; expectations follow ESC_ENTER_CRLF_EN when defined.
module tb_esc_seq_encoder;

  localparam logic [2:0] C_CHAR  = 3'd0;
  localparam logic [2:0] C_LEFT  = 3'd1;
  localparam logic [2:0] C_RIGHT = 3'd2;
  localparam logic [2:0] C_DEL   = 3'd3;
  localparam logic [2:0] C_SPACE = 3'd4;
  localparam logic [2:0] C_BS    = 3'd5;
  localparam logic [2:0] C_ENTER = 3'd6;
  localparam logic [2:0] C_RSVD  = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [2:0] key_code;
  logic [7:0] key_char;
  logic       key_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       err;

  int checks = 0;
  int errors = 0;

  esc_seq_encoder #(
    .BS_CODE (8'h7F)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_char  (key_char),
    .key_ready (key_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_key(input string tag, input logic [2:0] code, input logic [7:0] ch);
    key_valid = 1'b1;
    key_code  = code;
    key_char  = ch;
    check({tag, " key_ready before accept"}, {7'd0, key_ready}, 8'd1);
    tick();
    key_valid = 1'b0;
  endtask

  // Expects n bytes (MSB-first in seq) on consecutive cycles with tx_ready held high.
  task automatic run_seq(input string tag, input logic [31:0] seq, input int n);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s byte%0d valid", tag, i), {7'd0, tx_valid}, 8'd1);
      check($sformatf("%s byte%0d data", tag, i), tx_data, seq[31-8*i -: 8]);
      check($sformatf("%s byte%0d key_ready", tag, i), {7'd0, key_ready}, 8'd0);
      tick();
    end
    check({tag, " end tx_valid"}, {7'd0, tx_valid}, 8'd0);
    check({tag, " end key_ready"}, {7'd0, key_ready}, 8'd1);
  endtask

  task automatic drop_key(input string tag, input logic [2:0] code, input logic [7:0] ch);
    send_key(tag, code, ch);
    check({tag, " tx_valid"}, {7'd0, tx_valid}, 8'd0);
    check({tag, " err pulse"}, {7'd0, err}, 8'd1);
    check({tag, " key_ready"}, {7'd0, key_ready}, 8'd1);
    tick();
    check({tag, " err cleared"}, {7'd0, err}, 8'd0);
    check({tag, " tx_valid after"}, {7'd0, tx_valid}, 8'd0);
  endtask

  initial begin
    logic [31:0] del_seq;
    int          idx;

    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 3'd0;
    key_char  = 8'h00;
    tx_ready  = 1'b1;
    tick();
    tick();
    check("reset tx_valid", {7'd0, tx_valid}, 8'd0);
    check("reset tx_data", tx_data, 8'h00);
    check("reset err", {7'd0, err}, 8'd0);
    check("reset key_ready", {7'd0, key_ready}, 8'd1);
    rst = 1'b0;
    tick();

    send_key("left", C_LEFT, 8'h00);
    run_seq("left", 32'h1B5B4400, 3);

    // DELETE with tx_ready toggling 1,0,1,0,...; each byte must hold while stalled.
    del_seq = 32'h1B5B337E;
    idx     = 0;
    send_key("delete", C_DEL, 8'h00);
    for (int k = 0; k < 7; k++) begin
      tx_ready = (k % 2 == 0);
      check($sformatf("delete cyc%0d valid", k), {7'd0, tx_valid}, 8'd1);
      check($sformatf("delete cyc%0d data", k), tx_data, del_seq[31-8*idx -: 8]);
      tick();
      if (k % 2 == 0) idx++;
    end
    check("delete end tx_valid", {7'd0, tx_valid}, 8'd0);
    check("delete end key_ready", {7'd0, key_ready}, 8'd1);
    tx_ready = 1'b1;

    send_key("char41", C_CHAR, 8'h41);
    run_seq("char41", 32'h41000000, 1);
    send_key("char7e", C_CHAR, 8'h7E);
    run_seq("char7e", 32'h7E000000, 1);
    send_key("char20", C_CHAR, 8'h20);
    run_seq("char20", 32'h20000000, 1);
    drop_key("char07", C_CHAR, 8'h07);
    drop_key("char1f", C_CHAR, 8'h1F);
    drop_key("char7f", C_CHAR, 8'h7F);
    drop_key("rsvd", C_RSVD, 8'h41);

    send_key("enter", C_ENTER, 8'h00);
`ifdef ESC_ENTER_CRLF_EN
    run_seq("enter", 32'h0D0A0000, 2);
`else
    run_seq("enter", 32'h0D000000, 1);
`endif
    send_key("backspace", C_BS, 8'h00);
    run_seq("backspace", 32'h7F000000, 1);
    send_key("space", C_SPACE, 8'h00);
    run_seq("space", 32'h20000000, 1);

    // Reset mid-sequence after 1B and 5B of RIGHT have been handshaken.
    send_key("right_rst", C_RIGHT, 8'h00);
    check("right_rst b0", tx_data, 8'h1B);
    tick();
    check("right_rst b1", tx_data, 8'h5B);
    tick();
    rst = 1'b1;
    #1;
    check("midrst tx_valid", {7'd0, tx_valid}, 8'd0);
    check("midrst tx_data", tx_data, 8'h00);
    check("midrst key_ready", {7'd0, key_ready}, 8'd1);
    check("midrst err", {7'd0, err}, 8'd0);
    #2;
    rst = 1'b0;
    tick();
    send_key("left_after_rst", C_LEFT, 8'h00);
    run_seq("left_after_rst", 32'h1B5B4400, 3);

    // key_valid held across busy: SPACE, then RIGHT accepted after one idle cycle.
    key_valid = 1'b1;
    key_code  = C_SPACE;
    key_char  = 8'h00;
    tick();
    key_code = C_RIGHT;
    check("held space valid", {7'd0, tx_valid}, 8'd1);
    check("held space data", tx_data, 8'h20);
    check("held busy key_ready", {7'd0, key_ready}, 8'd0);
    tick();
    check("held gap tx_valid", {7'd0, tx_valid}, 8'd0);
    check("held gap key_ready", {7'd0, key_ready}, 8'd1);
    tick();
    key_valid = 1'b0;
    run_seq("held right", 32'h1B5B4300, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
